// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FWFT FIFO and its RAM wrapper.
package fifo_pkg;

  // RAM read latency: one extra cycle when the output register is enabled.
  function automatic int unsigned rd_latency(input bit dout_reg);
    return dout_reg ? 32'd2 : 32'd1;
  endfunction

  // Number of RAM words for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned width_addr);
    return 32'd1 << width_addr;
  endfunction

  // Prefetch entries needed to cover the read latency at full throughput.
  function automatic int unsigned prefetch_depth(input int unsigned lat);
    return lat + 32'd1;
  endfunction

  // Occupancy count width: must represent 0..DEPTH inclusive.
  function automatic int unsigned count_width(input int unsigned width_addr);
    return width_addr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Producer/consumer handshake bundle of the FWFT FIFO.
interface sync_fifo_fwft_if #(
  parameter int unsigned WIDTH_DATA = 64,
  parameter int unsigned WIDTH_ADDR = 5
);
  logic                  wr_en;
  logic [WIDTH_DATA-1:0] din;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [WIDTH_DATA-1:0] dout;
  logic                  empty;
  logic [WIDTH_ADDR:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en,
    input  full, almost_full, dout, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output full, almost_full, dout, empty, count, overflow, underflow
  );
endinterface

// File: rtl/mem_1r1w_xilinx.sv
// Simple dual-port RAM wrapper: one write port, one read port with optional output register.
module mem_1r1w_xilinx
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH_DATA      = 64,
  parameter int unsigned WIDTH_ADDR      = 5,
  parameter string       DEVICE_RAM_TYPE = "AUTO",
  parameter string       DOUT_REG        = "false"
) (
  input  logic                  wclk,
  input  logic                  wen,
  input  logic [WIDTH_ADDR-1:0] waddr,
  input  logic [WIDTH_DATA-1:0] wdata,
  input  logic                  rclk,
  input  logic                  ren,
  input  logic [WIDTH_ADDR-1:0] raddr,
  input  logic                  regceb,
  output logic [WIDTH_DATA-1:0] rdata
);
  localparam int unsigned DEPTH = fifo_depth(WIDTH_ADDR);

  logic [WIDTH_DATA-1:0] rd_q;

  if (DEVICE_RAM_TYPE == "distributed") begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH_DATA-1:0] mem [DEPTH];
    // Write port
    always_ff @(posedge wclk) if (wen) mem[waddr] <= wdata;
    // Read port, read-first
    always_ff @(posedge rclk) if (ren) rd_q <= mem[raddr];
  end else if (DEVICE_RAM_TYPE == "block") begin : g_block
    (* ram_style = "block" *) logic [WIDTH_DATA-1:0] mem [DEPTH];
    // Write port
    always_ff @(posedge wclk) if (wen) mem[waddr] <= wdata;
    // Read port, read-first
    always_ff @(posedge rclk) if (ren) rd_q <= mem[raddr];
  end else if (DEVICE_RAM_TYPE == "ultra") begin : g_ultra
    (* ram_style = "ultra" *) logic [WIDTH_DATA-1:0] mem [DEPTH];
    // Write port
    always_ff @(posedge wclk) if (wen) mem[waddr] <= wdata;
    // Read port, read-first
    always_ff @(posedge rclk) if (ren) rd_q <= mem[raddr];
  end else begin : g_auto
    logic [WIDTH_DATA-1:0] mem [DEPTH];
    // Write port
    always_ff @(posedge wclk) if (wen) mem[waddr] <= wdata;
    // Read port, read-first
    always_ff @(posedge rclk) if (ren) rd_q <= mem[raddr];
  end

  if (rd_latency(DOUT_REG == "true") == 32'd2) begin : g_oreg
    logic [WIDTH_DATA-1:0] out_q;
    // Optional output register stage
    always_ff @(posedge rclk) if (regceb) out_q <= rd_q;
    assign rdata = out_q;
  end else begin : g_onoreg
    logic unused_regceb;
    assign unused_regceb = regceb;
    assign rdata         = rd_q;
  end
endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: RAM storage plus a small prefetch queue
// that hides the RAM read latency so dout is valid whenever empty is low.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH_DATA      = 64,
  parameter int unsigned WIDTH_ADDR      = 5,
  parameter string       DEVICE_RAM_TYPE = "AUTO",
  parameter string       DOUT_REG        = "false",
  parameter int unsigned AF_LEVEL        = fifo_depth(WIDTH_ADDR) - 32'd4
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_fwft_if.slave bus
);
  localparam int unsigned DEPTH     = fifo_depth(WIDTH_ADDR);
  localparam int unsigned L         = rd_latency(DOUT_REG == "true");
  localparam int unsigned P         = prefetch_depth(L);
  localparam int unsigned WIDTH_CNT = count_width(WIDTH_ADDR);
  localparam int unsigned WIDTH_PF  = $clog2(P + L + 1);

  typedef logic [WIDTH_CNT-1:0]  count_t;
  typedef logic [WIDTH_PF-1:0]   pf_cnt_t;
  typedef logic [WIDTH_ADDR-1:0] addr_t;
  typedef logic [WIDTH_DATA-1:0] data_t;

  addr_t   wptr_q, rptr_q, wptr_n, rptr_n;
  count_t  ram_occ_q, count_q, ram_occ_n, count_n;
  logic [L-1:0] vpipe_q, vpipe_n;
  data_t   pbuf_q [P];
  data_t   pbuf_n [P];
  pf_cnt_t pbuf_cnt_q, pbuf_cnt_n;
  logic    full_q, af_q, empty_q, ovf_q, unf_q;
  logic    full_n, af_n, empty_n, ovf_n, unf_n;

  logic    push, pop, issue, arrive;
  pf_cnt_t inflight, committed, pbuf_kept;
  data_t   ram_rdata;

  mem_1r1w_xilinx #(
    .WIDTH_DATA      (WIDTH_DATA),
    .WIDTH_ADDR      (WIDTH_ADDR),
    .DEVICE_RAM_TYPE (DEVICE_RAM_TYPE),
    .DOUT_REG        (DOUT_REG)
  ) u_mem (
    .wclk   (clk),
    .wen    (push),
    .waddr  (wptr_q),
    .wdata  (bus.din),
    .rclk   (clk),
    .ren    (issue),
    .raddr  (rptr_q),
    .regceb (1'b1),
    .rdata  (ram_rdata)
  );

  // Next-state: accept/issue decisions, counters, read-valid pipe and prefetch queue
  always_comb begin
    push      = bus.wr_en && !full_q;
    pop       = bus.rd_en && !empty_q;
    arrive    = vpipe_q[L-1];
    inflight  = '0;
    for (int i = 0; i < L; i++) inflight = inflight + pf_cnt_t'(vpipe_q[i]);
    committed = inflight + pbuf_cnt_q - pf_cnt_t'(pop);
    issue     = (ram_occ_q != '0) && (committed < pf_cnt_t'(P));

    wptr_n    = push  ? wptr_q + addr_t'(1) : wptr_q;
    rptr_n    = issue ? rptr_q + addr_t'(1) : rptr_q;
    ram_occ_n = ram_occ_q + count_t'(push) - count_t'(issue);
    count_n   = count_q + count_t'(push) - count_t'(pop);

    vpipe_n[0] = issue;
    for (int i = 1; i < L; i++) vpipe_n[i] = vpipe_q[i-1];

    // Pop shifts the queue toward the head; returning RAM data lands behind the survivors
    for (int i = 0; i < P; i++) pbuf_n[i] = pbuf_q[i];
    if (pop) begin
      for (int i = 0; i < P - 1; i++) pbuf_n[i] = pbuf_q[i+1];
    end
    pbuf_kept = pbuf_cnt_q - pf_cnt_t'(pop);
    for (int i = 0; i < P; i++) begin
      if (arrive && (pf_cnt_t'(i) == pbuf_kept)) pbuf_n[i] = ram_rdata;
    end
    pbuf_cnt_n = pbuf_kept + pf_cnt_t'(arrive);

    full_n  = (count_n == count_t'(DEPTH));
    af_n    = (count_n >= count_t'(AF_LEVEL));
    empty_n = (pbuf_cnt_n == '0);
    ovf_n   = bus.wr_en && full_q;
    unf_n   = bus.rd_en && empty_q;
  end

  // State and registered outputs; in-flight reads are dropped on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_occ_q  <= '0;
      count_q    <= '0;
      vpipe_q    <= '0;
      pbuf_cnt_q <= '0;
      for (int i = 0; i < P; i++) pbuf_q[i] <= '0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_n;
      rptr_q     <= rptr_n;
      ram_occ_q  <= ram_occ_n;
      count_q    <= count_n;
      vpipe_q    <= vpipe_n;
      pbuf_cnt_q <= pbuf_cnt_n;
      for (int i = 0; i < P; i++) pbuf_q[i] <= pbuf_n[i];
      full_q     <= full_n;
      af_q       <= af_n;
      empty_q    <= empty_n;
      ovf_q      <= ovf_n;
      unf_q      <= unf_n;
    end
  end

  assign bus.dout        = pbuf_q[0];
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed scoreboard bench for sync_fifo_fwft, run once per RAM read latency.
module tb_sync_fifo_fwft;
  localparam int unsigned WD    = 64;
  localparam int unsigned WA    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AF    = 28;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, sel;
  logic [WD-1:0] din;

  always #5 clk = ~clk;

  sync_fifo_fwft_if #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA)) if0 ();
  sync_fifo_fwft_if #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA)) if1 ();

  assign if0.wr_en = wr_en;
  assign if0.din   = din;
  assign if0.rd_en = rd_en;
  assign if1.wr_en = wr_en;
  assign if1.din   = din;
  assign if1.rd_en = rd_en;

  sync_fifo_fwft #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .DEVICE_RAM_TYPE("AUTO"), .DOUT_REG("false"))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  sync_fifo_fwft #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .DEVICE_RAM_TYPE("block"), .DOUT_REG("true"))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [WD-1:0] o_dout;
  logic [WA:0]   o_count;
  logic          o_empty, o_full, o_af, o_ovf, o_unf;
  assign o_dout  = sel ? if1.dout        : if0.dout;
  assign o_count = sel ? if1.count       : if0.count;
  assign o_empty = sel ? if1.empty       : if0.empty;
  assign o_full  = sel ? if1.full        : if0.full;
  assign o_af    = sel ? if1.almost_full : if0.almost_full;
  assign o_ovf   = sel ? if1.overflow    : if0.overflow;
  assign o_unf   = sel ? if1.underflow   : if0.underflow;

  int            checks = 0;
  int            errors = 0;
  int            lat;
  logic [WD-1:0] sb [$];

  task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (L=%0d): observed 0x%0h expected 0x%0h", tag, lat, obs, exp);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1
  task automatic cycle(input logic we, input logic [WD-1:0] d, input logic re);
    logic push_ok, pop_ok, exp_ovf, exp_unf;
    int   n;
    wr_en   = we;
    din     = d;
    rd_en   = re;
    n       = sb.size();
    push_ok = we && (n < DEPTH);
    pop_ok  = re && (n > 0);
    exp_ovf = we && (n == DEPTH);
    exp_unf = re && (n == 0);
    if (pop_ok) begin
      chk("head_valid", 64'(o_empty), 64'd0);
      chk("head_data", o_dout, sb[0]);
      void'(sb.pop_front());
    end
    if (push_ok) sb.push_back(d);
    n = sb.size();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("count", 64'(o_count), 64'(n));
    chk("full", 64'(o_full), 64'(n == DEPTH));
    chk("almost_full", 64'(o_af), 64'(n >= AF));
    chk("overflow", 64'(o_ovf), 64'(exp_ovf));
    chk("underflow", 64'(o_unf), 64'(exp_unf));
  endtask

  task automatic settle();
    repeat (lat + 3) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    sel   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    lat   = 1;
    for (int p = 0; p < 2; p++) begin
      sel = (p == 1);
      lat = (p == 1) ? 2 : 1;

      // Reset values
      do_reset();
      chk("rst_empty", 64'(o_empty), 64'd1);
      chk("rst_full", 64'(o_full), 64'd0);
      chk("rst_af", 64'(o_af), 64'd0);
      chk("rst_count", 64'(o_count), 64'd0);
      chk("rst_dout", o_dout, 64'd0);
      chk("rst_ovf", 64'(o_ovf), 64'd0);
      chk("rst_unf", 64'(o_unf), 64'd0);

      // Single push: head appears exactly L+2 cycles later
      cycle(1'b1, 64'hA5, 1'b0);
      for (int k = 1; k < lat + 2; k++) begin
        chk("latency_empty", 64'(o_empty), 64'd1);
        cycle(1'b0, '0, 1'b0);
      end
      chk("latency_ready", 64'(o_empty), 64'd0);
      chk("latency_dout", o_dout, 64'hA5);
      cycle(1'b0, '0, 1'b1);

      // Fill to full; 33rd push overflows and is dropped
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'(i), 1'b0);
      cycle(1'b1, 64'hDEAD, 1'b0);
      settle();

      // Full with push+pop: pop wins, push dropped, overflow pulses
      cycle(1'b1, 64'hBEEF, 1'b1);
      for (int i = 1; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);

      // Empty: lone pop underflows; push+pop keeps the push
      cycle(1'b0, '0, 1'b1);
      cycle(1'b1, 64'h77, 1'b1);
      settle();
      cycle(1'b0, '0, 1'b1);

      // Prime 4, then 200 cycles of push+pop with no bubbles (wraps the pointers)
      for (int i = 0; i < 4; i++) cycle(1'b1, 64'(32'h1000 + i), 1'b0);
      settle();
      for (int i = 4; i < 204; i++) cycle(1'b1, 64'(32'h1000 + i), 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

      // Reset with reads in flight; fresh data afterwards must be intact
      cycle(1'b1, 64'h61, 1'b0);
      cycle(1'b1, 64'h62, 1'b0);
      cycle(1'b1, 64'h63, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_empty", 64'(o_empty), 64'd1);
      chk("midrst_count", 64'(o_count), 64'd0);
      chk("midrst_dout", o_dout, 64'd0);
      @(posedge clk);
      #1;
      chk("midrst_empty_hold", 64'(o_empty), 64'd1);
      chk("midrst_dout_hold", o_dout, 64'd0);
      rst = 1'b0;
      sb.delete();
      cycle(1'b1, 64'h5A5A_0000_0000_0001, 1'b0);
      settle();
      chk("fresh_dout", o_dout, 64'h5A5A_0000_0000_0001);
      cycle(1'b0, '0, 1'b1);
      settle();
      chk("final_empty", 64'(o_empty), 64'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
